fifo_frame_unpacker: RTL and testbench
======================================

# fifo_frame_unpacker

Read-side consumer of the async_fifo in the `clk_out` domain. Pops 140-bit frames from the FIFO read port, decodes the frame header and streams the payload out one byte per beat on a valid/ready interface with channel tag and last flag. Keeps saturating frame and drop counters for status readout.

## Interface
- `DW`, 140: frame width; fixed layout, see Operation.
- `CW`, 16: width of the status counters.
- `clk_out`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag, read domain.
- `fifo_r_enable`  out  1  FIFO pop request.
- `data_from_fifo`  in  DW  FIFO read data; the FIFO updates it on the edge that samples `fifo_r_enable`=1.
- `out_valid`  out  1  byte beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  8  payload byte.
- `out_chan`  out  4  channel id of the current frame.
- `out_last`  out  1  last byte of the frame.
- `frame_cnt`  out  CW  frames fully emitted; saturates at all-ones.
- `drop_cnt`  out  CW  frames discarded; saturates at all-ones.

## Operation
- Frame layout: [139:136] channel, [135:128] byte count N, [127:0] payload. Byte k = payload[8k+7:8k]; byte 0 goes first.
- N = 0: the frame is dropped, no beats are emitted, and `drop_cnt` increments.
- N > 16: clamped to 16; the frame is still emitted (not a drop).
- FSM states:
  - IDLE: `fifo_r_enable`=0. Go to REQ when `fifo_empty`=0 at the edge.
  - REQ: `fifo_r_enable`=1 for exactly one cycle. Always go to CAP.
  - CAP: at the edge, register channel, clamped N and payload, and clear the byte index. If N=0, increment `drop_cnt` and go to IDLE; otherwise go to SEND.
  - SEND: `out_valid`=1 and `out_data` = byte[index]. On `out_valid` & `out_ready`, index increments. On the handshake with index = N-1, increment `frame_cnt` and go to IDLE.
- `out_last` = (state == SEND) & (index == N-1).
- `out_data` and `out_chan` are held stable while `out_valid`=1 and `out_ready`=0.
- Valid/ready rule: `out_valid` never drops without a handshake, and it does not depend combinationally on `out_ready`.
- Only one pop is in flight at a time. `fifo_r_enable` is a Moore output of REQ only, so the block never pops an empty FIFO.
- Counters: 16-bit saturating. Both may increment only in different cycles, since they come from distinct states.

## Timing
- Reset values: state IDLE; `fifo_r_enable`=0; `out_valid`=0; `out_last`=0; `out_data`=0; `out_chan`=0; index 0; `frame_cnt`=0; `drop_cnt`=0.
- Latency: `fifo_empty` is sampled low at edge E0. Then `fifo_r_enable`=1 during E0..E1, data is captured at E2, and `out_valid`=1 from E2.
- Throughput with `out_ready` held at 1: a frame of N bytes takes N + 3 cycles (IDLE, REQ, CAP, N beats).
- A dropped frame takes 3 cycles.
- Back-to-back frames: after the last handshake the FSM is in IDLE and samples `fifo_empty` in that same cycle.
- `rst` asserted mid-frame: all outputs are forced to reset values immediately (asynchronous). The remaining bytes of the frame are lost and no counter increments. A pop already taken stays consumed.
- `fifo_empty` rising while in REQ/CAP/SEND has no effect; it is sampled only in IDLE.

## Structure
- Package `fifo_frame_pkg`:
  - field constants `CHAN_MSB`=139, `CHAN_LSB`=136, `LEN_MSB`=135, `LEN_LSB`=128, `PAYLOAD_W`=128, `MAX_BYTES`=16;
  - enum `unpack_state_t` {IDLE, REQ, CAP, SEND};
  - `DW`=140, shared with async_fifo.
- One natural sub-module: `sat_counter` (width parameter, inc, value), instantiated twice.
- Byte select is a 16:1 mux on the 4-bit index; no shift register.

## Test plan
- Reset: drive `rst`=1 for 3 cycles → every output 0, `fifo_r_enable` never 1.
- Single frame: chan 4'h3, N=3, payload[23:0]=24'hCCBBAA, `out_ready`=1 → `out_data` AA, BB, CC; `out_chan`=3; `out_last` only on CC; `out_valid` 3 cycles after empty falls; `frame_cnt`=1.
- Backpressure: N=2, `out_ready` low for 5 cycles on byte 0 → `out_data`/`out_valid` stable throughout, then 2 beats; exactly one pop.
- Drop and clamp: frame N=0, then frame N=8'd40 → `drop_cnt`=1, no beats for the first frame; 16 beats for the second, `out_last` on the 16th.
- Back-to-back: 2 frames of N=16 queued, `out_ready`=1 → 38 cycles total, two pops, `frame_cnt`=2.
- Mid-frame reset: assert `rst` after beat 1 of an N=4 frame → `out_valid`=0 asynchronously, counters 0; a following frame is emitted correctly.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// fifo_frame_pkg
// Shared definitions for the frame path between async_fifo and the
// read-side unpacker: frame width, header field positions, unpacker
// state encoding and the byte-count clamp helper.
package fifo_frame_pkg;

  // Frame width, shared with async_fifo.
  localparam int DW        = 140;

  // Header and payload field positions inside one frame.
  localparam int CHAN_MSB  = 139;
  localparam int CHAN_LSB  = 136;
  localparam int LEN_MSB   = 135;
  localparam int LEN_LSB   = 128;
  localparam int PAYLOAD_W = 128;
  localparam int MAX_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } unpack_state_t;

  // Byte counts above the payload capacity are clamped rather than dropped.
  function automatic logic [4:0] clamp_len(input logic [7:0] n);
    if (n > 8'(MAX_BYTES)) begin
      return 5'(MAX_BYTES);
    end else begin
      return n[4:0];
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   value - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  // Count register; holds once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/fifo_frame_unpacker.sv
// fifo_frame_unpacker
// Pops 140-bit frames from the read port of async_fifo, decodes the header
// (channel, byte count) and streams the payload out one byte per beat on a
// valid/ready interface. Frames with a zero byte count are dropped; counts
// above 16 are clamped. Saturating counters report emitted/dropped frames.
// Ports:
//   clk_out        - read-domain clock
//   rst            - asynchronous active-high reset
//   fifo_empty     - FIFO empty flag (sampled only while idle)
//   fifo_r_enable  - one-cycle pop request
//   data_from_fifo - FIFO read data, valid the cycle after the pop
//   out_valid/out_ready/out_data/out_chan/out_last - byte stream
//   frame_cnt      - frames fully emitted
//   drop_cnt       - frames discarded
module fifo_frame_unpacker #(
  parameter int DW = fifo_frame_pkg::DW,
  parameter int CW = 16
) (
  input  logic          clk_out,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_r_enable,
  input  logic [DW-1:0] data_from_fifo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [3:0]    out_chan,
  output logic          out_last,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] drop_cnt
);

  import fifo_frame_pkg::*;

  unpack_state_t        r_state;
  unpack_state_t        w_next_state;
  logic [3:0]           r_chan;
  logic [4:0]           r_len;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [3:0]           r_index;

  logic                 w_hs;
  logic                 w_last;
  logic                 w_frame_inc;
  logic                 w_drop_inc;
  logic [4:0]           w_cap_len;

  assign w_cap_len = clamp_len(data_from_fifo[LEN_MSB:LEN_LSB]);

  // Both flags are Moore outputs of the state, so valid never looks at ready
  // and a pop can only follow an idle cycle that saw the FIFO non-empty.
  assign fifo_r_enable = (r_state == REQ);
  assign out_valid     = (r_state == SEND);
  assign w_hs          = out_valid & out_ready;
  assign w_last        = ({1'b0, r_index} == (r_len - 5'd1));
  assign out_last      = out_valid & w_last;
  assign out_chan      = r_chan;
  // 16:1 byte select; index and payload only move on a handshake or capture,
  // so the byte stays put under backpressure.
  assign out_data      = r_payload[{r_index, 3'b000} +: 8];

  // Next-state decode and counter increment strobes.
  always_comb begin
    w_next_state = r_state;
    w_frame_inc  = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_next_state = REQ;
        end else begin
          w_next_state = IDLE;
        end
      end
      REQ: begin
        w_next_state = CAP;
      end
      CAP: begin
        if (w_cap_len == 5'd0) begin
          w_next_state = IDLE;
          w_drop_inc   = 1'b1;
        end else begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (w_hs && w_last) begin
          w_next_state = IDLE;
          w_frame_inc  = 1'b1;
        end else begin
          w_next_state = SEND;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus frame capture and byte index.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_chan    <= 4'd0;
      r_len     <= 5'd0;
      r_payload <= '0;
      r_index   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == CAP) begin
        r_chan    <= data_from_fifo[CHAN_MSB:CHAN_LSB];
        r_len     <= w_cap_len;
        r_payload <= data_from_fifo[PAYLOAD_W-1:0];
        r_index   <= 4'd0;
      end else if (w_hs) begin
        // Wraps to 0 after byte 15; the FSM leaves SEND on that beat anyway.
        r_index <= r_index + 4'd1;
      end
    end
  end

  sat_counter #(.W(CW)) u_frame_cnt (
    .clk   (clk_out),
    .rst   (rst),
    .inc   (w_frame_inc),
    .value (frame_cnt)
  );

  sat_counter #(.W(CW)) u_drop_cnt (
    .clk   (clk_out),
    .rst   (rst),
    .inc   (w_drop_inc),
    .value (drop_cnt)
  );

endmodule

// File: tb/tb_fifo_frame_unpacker.sv
module tb_fifo_frame_unpacker;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] c;
    logic       l;
  } beat_t;

  logic         clk_out = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] data_from_fifo;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_chan;
  logic         out_last;
  logic [15:0]  frame_cnt;
  logic [15:0]  drop_cnt;

  logic [139:0] fq[$];     // FIFO contents
  beat_t        exp_q[$];  // expected byte stream
  int           exp_frames;
  int           exp_drops;
  int           n_checks;
  int           n_fail;
  int           pops;
  int           beats_seen;
  int           lasts_seen;
  bit           rand_ready;

  always #5 clk_out = ~clk_out;

  fifo_frame_unpacker #(.DW(140), .CW(16)) dut (
    .clk_out        (clk_out),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_chan       (out_chan),
    .out_last       (out_last),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  function void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Queue a frame in the FIFO and append what it must produce to the model.
  function void push_frame(input logic [3:0] ch, input logic [7:0] n, input logic [127:0] pl);
    int nb;
    beat_t b;
    fq.push_back({ch, n, pl});
    fifo_empty = 1'b0;
    if (n == 8'd0) begin
      exp_drops++;
    end else begin
      nb = (n > 8'd16) ? 16 : int'(n);
      for (int k = 0; k < nb; k++) begin
        b.d = pl[8*k +: 8];
        b.c = ch;
        b.l = (k == nb - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // One clock: FIFO read port reacts to a pop seen at the edge.
  task automatic tick();
    logic p;
    @(posedge clk_out);
    p = fifo_r_enable;
    #1;
    if (p) begin
      pops++;
      chk("pop_nonempty", 64'(fq.size() > 0), 64'd1);
      if (fq.size() > 0) data_from_fifo = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || fq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size() + fq.size()), 64'd0);
    repeat (4) tick();
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    logic  prev_stall;
    logic [7:0] prev_data;
    logic [3:0] prev_chan;
    beat_t e;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    prev_chan  = 4'd0;
    forever begin
      @(negedge clk_out);
      if (rst) begin
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ren", 64'(fifo_r_enable), 64'd0);
        chk("rst_outs", {out_data, out_chan, out_last}, 64'd0);
        chk("rst_cnts", {frame_cnt, drop_cnt}, 64'd0);
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(prev_data));
          chk("hold_chan", 64'(out_chan), 64'(prev_chan));
        end
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q[0];
            chk("beat_data", 64'(out_data), 64'(e.d));
            chk("beat_chan", 64'(out_chan), 64'(e.c));
            chk("beat_last", 64'(out_last), 64'(e.l));
            if (out_ready) begin
              void'(exp_q.pop_front());
              beats_seen++;
              if (out_last) lasts_seen++;
              if (e.l) exp_frames++;
            end
          end
        end else begin
          chk("last_wo_valid", 64'(out_last), 64'd0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_chan  = out_chan;
      end
    end
  end

  initial begin
    int p0, b0, l0, cyc, f0;
    logic [7:0] n;
    n_checks = 0; n_fail = 0; pops = 0; beats_seen = 0; lasts_seen = 0;
    exp_frames = 0; exp_drops = 0; rand_ready = 1'b0;
    rst = 1'b1; fifo_empty = 1'b1; out_ready = 1'b0; data_from_fifo = '0;

    // Reset
    repeat (3) tick();
    chk("reset_state", {out_valid, fifo_r_enable, out_last, out_data, out_chan}, 64'd0);
    rst = 1'b0;
    tick();

    // Single frame, latency and literal bytes
    out_ready = 1'b1;
    p0 = pops;
    push_frame(4'h3, 8'd3, 128'hCCBBAA);
    tick(); tick();
    chk("lat_early", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("b0_lit", {out_data, out_chan, out_last}, {8'hAA, 4'h3, 1'b0});
    tick();
    chk("b1_lit", {out_data, out_last}, {8'hBB, 1'b0});
    tick();
    chk("b2_lit", {out_data, out_last}, {8'hCC, 1'b1});
    tick();
    chk("single_done", {out_valid, frame_cnt}, {1'b0, 16'd1});
    chk("single_pops", 64'(pops - p0), 64'd1);

    // Backpressure
    out_ready = 1'b0;
    p0 = pops;
    push_frame(4'h7, 8'd2, 128'h2211);
    wait_valid();
    repeat (5) begin
      tick();
      chk("bp_hold", {out_valid, out_data}, {1'b1, 8'h11});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_b1", {out_valid, out_data, out_last}, {1'b1, 8'h22, 1'b1});
    tick();
    chk("bp_end", 64'(out_valid), 64'd0);
    chk("bp_pops", 64'(pops - p0), 64'd1);
    repeat (2) tick();

    // Drop then clamp
    b0 = beats_seen; l0 = lasts_seen;
    push_frame(4'h5, 8'd0, {$urandom, $urandom, $urandom, $urandom});
    push_frame(4'h9, 8'd40, {$urandom, $urandom, $urandom, $urandom});
    drain(200);
    chk("drop_cnt_lit", 64'(drop_cnt), 64'd1);
    chk("clamp_beats", 64'(beats_seen - b0), 64'd16);
    chk("clamp_lasts", 64'(lasts_seen - l0), 64'd1);
    chk("frame_cnt_lit", 64'(frame_cnt), 64'd3);

    // Back-to-back
    p0 = pops;
    f0 = int'(frame_cnt);
    push_frame(4'hA, 8'd16, {$urandom, $urandom, $urandom, $urandom});
    push_frame(4'hB, 8'd16, {$urandom, $urandom, $urandom, $urandom});
    cyc = 0;
    while (int'(frame_cnt) < f0 + 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("b2b_cycles", 64'(cyc), 64'd38);
    chk("b2b_pops", 64'(pops - p0), 64'd2);
    drain(50);

    // Mid-frame reset
    push_frame(4'h6, 8'd4, 128'h44332211);
    wait_valid();
    tick(); tick();
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    #1;
    chk("async_rst", {out_valid, out_data, out_chan, frame_cnt, drop_cnt}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    push_frame(4'hC, 8'd5, 128'h5544332211);
    drain(50);
    chk("post_rst_frames", 64'(frame_cnt), 64'd1);

    // Randomized traffic
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      while (fq.size() >= 3) tick();
      case ($urandom_range(0, 5))
        0:       n = 8'd0;
        1:       n = 8'($urandom_range(17, 255));
        2:       n = 8'd16;
        default: n = 8'($urandom_range(1, 15));
      endcase
      push_frame(4'($urandom), n, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    drain(3000);
    chk("rand_frames", 64'(frame_cnt), 64'(exp_frames));
    chk("rand_drops", 64'(drop_cnt), 64'(exp_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
